// File: rtl/riscv_dmem_if.sv
// Bus bundle between a RV32 core and its combined instruction/data memory responder.
// The master side issues fetch and load/store requests; the slave side returns registered results.
interface riscv_dmem_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] instruction_addr;
    logic [XLEN-1:0] instruction;
    logic            ifault;
    logic [XLEN-1:0] mem_addr;
    logic            memfetch;
    logic            memwrite;
    logic [2:0]      funct3;
    logic [XLEN-1:0] memwdata;
    logic [XLEN-1:0] memread;
    logic            dfault;

    modport master (
        output instruction_addr, mem_addr, memfetch, memwrite, funct3, memwdata,
        input  instruction, ifault, memread, dfault
    );

    modport slave (
        input  instruction_addr, mem_addr, memfetch, memwrite, funct3, memwdata,
        output instruction, ifault, memread, dfault
    );
endinterface

// File: rtl/riscv_dmem_responder.sv
// Single-cycle instruction fetch + data load/store responder over a little-endian word array,
// with a one-entry store buffer that forwards its bytes to both ports.
module riscv_dmem_responder #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 1024
) (
    input  logic          clk,
    input  logic          rst,
    riscv_dmem_if.slave   bus
);
    localparam int              ABITS = $clog2(DEPTH);
    localparam logic [XLEN-1:0] NOP   = XLEN'(32'h0000_0013);

    typedef logic [ABITS-1:0] idx_t;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef struct packed {
        logic            valid;
        idx_t            idx;
        logic [3:0]      mask;
        logic [XLEN-1:0] data;
    } sbuf_t;

    logic [XLEN-1:0] mem [DEPTH];
    sbuf_t           sb;

    logic [XLEN-1:0] instruction_q;
    logic            ifault_q;
    logic [XLEN-1:0] memread_q;
    logic            dfault_q;

    idx_t            i_idx;
    idx_t            d_idx;
    logic            i_fault;
    logic            d_fault;
    logic [1:0]      lane;
    logic            is_ld;
    logic            is_st;
    logic [3:0]      st_mask;
    logic [XLEN-1:0] st_data;
    logic [XLEN-1:0] ld_word;
    logic [XLEN-1:0] ld_shift;
    logic [XLEN-1:0] ld_val;

    // Pending store bytes override the array copy of the same word.
    function automatic logic [XLEN-1:0] fwd(input idx_t idx, input logic [XLEN-1:0] arr,
                                            input sbuf_t b);
        logic [XLEN-1:0] w;
        w = arr;
        for (int i = 0; i < 4; i++) begin
            if (b.valid && b.idx == idx && b.mask[i]) w[8*i +: 8] = b.data[8*i +: 8];
        end
        return w;
    endfunction

    // NOTE: every signal assigned here gets a default before the case, so no latch is inferred.
    always_comb begin
        i_idx    = bus.instruction_addr[ABITS+1:2];
        i_fault  = (bus.instruction_addr[1:0] != 2'b00) ||
                   (|bus.instruction_addr[XLEN-1:ABITS+2]);
        d_idx    = bus.mem_addr[ABITS+1:2];
        lane     = bus.mem_addr[1:0];
        is_ld    = bus.memfetch && !bus.memwrite;
        is_st    = bus.memwrite && !bus.memfetch;
        d_fault  = (|bus.mem_addr[XLEN-1:ABITS+2]) || (bus.memfetch && bus.memwrite);
        st_mask  = 4'b0000;
        st_data  = '0;
        ld_val   = '0;
        ld_word  = fwd(d_idx, mem[d_idx], sb);
        ld_shift = ld_word >> {lane, 3'b000};

        case (funct3_e'(bus.funct3))
            F3_B: begin
                ld_val  = {{24{ld_shift[7]}}, ld_shift[7:0]};
                st_mask = 4'b0001 << lane;
                st_data = {4{bus.memwdata[7:0]}};
            end
            F3_H: begin
                d_fault = d_fault || lane[0];
                ld_val  = {{16{ld_shift[15]}}, ld_shift[15:0]};
                st_mask = 4'b0011 << lane;
                st_data = {2{bus.memwdata[15:0]}};
            end
            F3_W: begin
                d_fault = d_fault || (lane != 2'b00);
                ld_val  = ld_shift;
                st_mask = 4'b1111;
                st_data = bus.memwdata;
            end
            F3_BU: begin
                d_fault = d_fault || is_st;
                ld_val  = {24'b0, ld_shift[7:0]};
            end
            F3_HU: begin
                d_fault = d_fault || is_st || lane[0];
                ld_val  = {16'b0, ld_shift[15:0]};
            end
            default: d_fault = 1'b1;
        endcase
    end

    // NOTE: the array carries no reset; only the buffered store is dropped when rst is high.
    always_ff @(posedge clk) begin
        if (!rst && sb.valid) begin
            for (int i = 0; i < 4; i++) begin
                if (sb.mask[i]) mem[sb.idx][8*i +: 8] <= sb.data[8*i +: 8];
            end
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            instruction_q <= NOP;
            ifault_q      <= 1'b0;
            memread_q     <= '0;
            dfault_q      <= 1'b0;
            sb            <= '0;
        end else begin
            if (i_fault) begin
                instruction_q <= NOP;
                ifault_q      <= 1'b1;
            end else begin
                instruction_q <= fwd(i_idx, mem[i_idx], sb);
                ifault_q      <= 1'b0;
            end

            if (bus.memfetch || bus.memwrite) begin
                dfault_q <= d_fault;
                if (d_fault)    memread_q <= '0;
                else if (is_ld) memread_q <= ld_val;
            end else begin
                dfault_q <= 1'b0;
            end

            // A fresh legal store replaces the entry committing on this same edge.
            if (is_st && !d_fault) sb <= '{valid: 1'b1, idx: d_idx, mask: st_mask, data: st_data};
            else                   sb.valid <= 1'b0;
        end
    end

    assign bus.instruction = instruction_q;
    assign bus.ifault      = ifault_q;
    assign bus.memread     = memread_q;
    assign bus.dfault      = dfault_q;
endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed bench for riscv_dmem_responder: a byte-level memory model predicts every output each
// cycle, and literal expectations at key points pin the model itself.
module tb_riscv_dmem_responder;
    localparam int          XLEN  = 32;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    riscv_dmem_if #(.XLEN(XLEN)) bus();

    riscv_dmem_responder #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Byte-addressed model: stores land immediately; the last one is undone if rst follows it.
    logic [7:0]  mdl [4*DEPTH];
    logic [31:0] exp_instr;
    logic [31:0] exp_rd;
    logic        exp_if;
    logic        exp_df;
    bit          live = 0;
    int          undo_n = 0;
    int          undo_a [4];
    logic [7:0]  undo_d [4];

    function automatic logic [31:0] rd_bytes(input int a, input int n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v |= 32'(mdl[a + i]) << (8 * i);
        return v;
    endfunction

    always @(posedge clk) begin : model
        int          sz;
        int          a;
        bit          ok;
        logic [31:0] v;
        if (rst) begin
            exp_instr = NOP;
            exp_if    = 1'b0;
            exp_rd    = '0;
            exp_df    = 1'b0;
            for (int i = 0; i < undo_n; i++) mdl[undo_a[i]] = undo_d[i];
            undo_n = 0;
        end else begin
            undo_n = 0;
            if (bus.instruction_addr % 4 != 0 || bus.instruction_addr >= 4 * DEPTH) begin
                exp_instr = NOP;
                exp_if    = 1'b1;
            end else begin
                exp_instr = rd_bytes(int'(bus.instruction_addr), 4);
                exp_if    = 1'b0;
            end
            if (bus.memfetch || bus.memwrite) begin
                sz = 1 << bus.funct3[1:0];
                a  = int'(bus.mem_addr);
                ok = !(bus.memfetch && bus.memwrite) && bus.mem_addr < 4 * DEPTH &&
                     (bus.mem_addr % sz) == 0 &&
                     (bus.memfetch ? (bus.funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                                   : (bus.funct3 inside {3'd0, 3'd1, 3'd2}));
                if (!ok) begin
                    exp_df = 1'b1;
                    exp_rd = '0;
                end else begin
                    exp_df = 1'b0;
                    if (bus.memfetch) begin
                        v = rd_bytes(a, sz);
                        if (!bus.funct3[2] && sz < 4 && v[8*sz-1]) v |= 32'hFFFF_FFFF << (8 * sz);
                        exp_rd = v;
                    end else begin
                        for (int i = 0; i < sz; i++) begin
                            undo_a[i]  = a + i;
                            undo_d[i]  = mdl[a + i];
                            mdl[a + i] = bus.memwdata[8*i +: 8];
                        end
                        undo_n = sz;
                    end
                end
            end else begin
                exp_df = 1'b0;
            end
        end
        live = 1;
    end

    always @(negedge clk) begin
        if (live) begin
            check("cyc_instruction", bus.instruction, exp_instr);
            check("cyc_ifault", {31'b0, bus.ifault}, {31'b0, exp_if});
            check("cyc_memread", bus.memread, exp_rd);
            check("cyc_dfault", {31'b0, bus.dfault}, {31'b0, exp_df});
        end
    end

    logic [31:0] fa = 32'h2;

    task automatic cyc(input logic [31:0] ma, input logic mf, input logic mw,
                       input logic [2:0] f3, input logic [31:0] wd);
        bus.instruction_addr = fa;
        bus.mem_addr         = ma;
        bus.memfetch         = mf;
        bus.memwrite         = mw;
        bus.funct3           = f3;
        bus.memwdata         = wd;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(32'h0, 1'b0, 1'b0, 3'd0, 32'h0);
    endtask

    task automatic ld(input logic [31:0] ma, input logic [2:0] f3);
        cyc(ma, 1'b1, 1'b0, f3, 32'h0);
    endtask

    task automatic st(input logic [31:0] ma, input logic [2:0] f3, input logic [31:0] wd);
        cyc(ma, 1'b0, 1'b1, f3, wd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.instruction_addr = fa;
        bus.mem_addr         = '0;
        bus.memfetch         = 1'b0;
        bus.memwrite         = 1'b0;
        bus.funct3           = 3'd0;
        bus.memwdata         = '0;
        rst = 1'b1;
        @(negedge clk);
        st(32'h40, 3'd2, 32'h1111_1111);
        check("rst_instruction", bus.instruction, NOP);
        check("rst_ifault", {31'b0, bus.ifault}, 32'h0);
        check("rst_memread", bus.memread, 32'h0);
        check("rst_dfault", {31'b0, bus.dfault}, 32'h0);
        rst = 1'b0;

        // Word store, then sized loads with sign/zero extension.
        st(32'h40, 3'd2, 32'hDEAD_BEEF);
        idle();
        ld(32'h40, 3'd2);
        check("lw_40", bus.memread, 32'hDEAD_BEEF);
        check("lw_40_dfault", {31'b0, bus.dfault}, 32'h0);
        ld(32'h43, 3'd0);
        check("lb_43", bus.memread, 32'hFFFF_FFDE);
        ld(32'h43, 3'd4);
        check("lbu_43", bus.memread, 32'h0000_00DE);
        ld(32'h42, 3'd5);
        check("lhu_42", bus.memread, 32'h0000_DEAD);
        idle();
        check("idle_hold", bus.memread, 32'h0000_DEAD);

        // Back-to-back stores to one word, then forwarded load.
        st(32'h80, 3'd2, 32'h1122_3344);
        st(32'h81, 3'd0, 32'h0000_00AA);
        ld(32'h80, 3'd2);
        check("lw_80_fwd", bus.memread, 32'h1122_AA44);

        // Data faults.
        ld(32'h41, 3'd2);
        check("lw_41_dfault", {31'b0, bus.dfault}, 32'h1);
        check("lw_41_memread", bus.memread, 32'h0);
        st(32'h43, 3'd1, 32'h0000_5555);
        check("sh_43_dfault", {31'b0, bus.dfault}, 32'h1);
        idle();
        check("idle_dfault_clr", {31'b0, bus.dfault}, 32'h0);
        ld(32'h40, 3'd2);
        check("lw_40_unchanged", bus.memread, 32'hDEAD_BEEF);
        cyc(32'h40, 1'b1, 1'b1, 3'd2, 32'h0);
        check("both_dfault", {31'b0, bus.dfault}, 32'h1);
        ld(32'h40, 3'd3);
        check("illegal_f3", {31'b0, bus.dfault}, 32'h1);
        ld(32'(4 * DEPTH), 3'd2);
        check("lw_oor", {31'b0, bus.dfault}, 32'h1);
        st(32'h44, 3'd4, 32'h0000_0077);
        check("sbu_illegal", {31'b0, bus.dfault}, 32'h1);

        // Fetch path.
        st(32'h0, 3'd2, 32'h0010_0093);
        idle();
        fa = 32'h0;
        idle();
        check("fetch_0", bus.instruction, 32'h0010_0093);
        check("fetch_0_ifault", {31'b0, bus.ifault}, 32'h0);
        fa = 32'h2;
        idle();
        check("fetch_2", bus.instruction, NOP);
        check("fetch_2_ifault", {31'b0, bus.ifault}, 32'h1);
        fa = 32'(4 * DEPTH);
        idle();
        check("fetch_oor_ifault", {31'b0, bus.ifault}, 32'h1);
        fa = 32'h2;

        // A store still buffered when rst rises is dropped.
        st(32'h10, 3'd2, 32'h1234_5678);
        idle();
        st(32'h10, 3'd2, 32'h0000_0055);
        rst = 1'b1;
        st(32'h10, 3'd2, 32'h0000_0099);
        check("rst2_memread", bus.memread, 32'h0);
        check("rst2_instruction", bus.instruction, NOP);
        rst = 1'b0;
        ld(32'h10, 3'd2);
        check("lw_10_after_rst", bus.memread, 32'h1234_5678);

        // Fetch and load of the just-stored word in the same cycle.
        st(32'h20, 3'd2, 32'hCAFE_F00D);
        fa = 32'h20;
        ld(32'h20, 3'd2);
        check("fetch_20_fwd", bus.instruction, 32'hCAFE_F00D);
        check("lw_20_fwd", bus.memread, 32'hCAFE_F00D);
        fa = 32'h2;

        // Halfword store and signed loads across lanes.
        st(32'h22, 3'd1, 32'h1234_BEEF);
        ld(32'h22, 3'd1);
        check("lh_22", bus.memread, 32'hFFFF_BEEF);
        ld(32'h20, 3'd1);
        check("lh_20", bus.memread, 32'hFFFF_F00D);
        ld(32'h20, 3'd0);
        check("lb_20", bus.memread, 32'h0000_000D);
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
